seg_capture: RTL and testbench

Seven-segment pattern receiver: the inverse of the board's hex-to-segment decoder. It samples an active-low, time-multiplexed segment bus (one shared segment code plus a one-hot digit select), debounces each digit, and encodes the pattern back to a 4-bit hex nibble. Once every digit has been captured, it presents the assembled frame through a valid/ack handshake. It sits between an external display-driver tap (or our own scanned display controller) and any logic that must read back what is being shown.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_encode.sv | 39 +++
 rtl/seg_capture.sv | 139 +++++++++++++
 tb/tb_seg_capture.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg
// Shared definitions for the seven-segment capture path.
//   SEG_0 .. SEG_F : active-low segment codes (bit0=a .. bit6=g) of the
//                    sixteen legal hex glyphs, as driven by the board's
//                    hex-to-segment decoder.
//   capState_t     : frame state of seg_capture (COLLECT, PRESENT).
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } capState_t;

endpackage

// File: rtl/seg_encode.sv
// seg_encode
// Purely combinational inverse of the hex-to-segment decoder.
//   i_seg     in  7  active-low segment code
//   o_nibble  out 4  recovered hex value (0 for an illegal code)
//   o_illegal out 1  set when i_seg is not one of the sixteen glyphs
module seg_encode
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_illegal
);

    // Unknown glyphs fall through to the default and report as illegal
    always_comb begin
        o_nibble  = 4'h0;
        o_illegal = 1'b0;
        case (i_seg)
            SEG_0:   o_nibble = 4'h0;
            SEG_1:   o_nibble = 4'h1;
            SEG_2:   o_nibble = 4'h2;
            SEG_3:   o_nibble = 4'h3;
            SEG_4:   o_nibble = 4'h4;
            SEG_5:   o_nibble = 4'h5;
            SEG_6:   o_nibble = 4'h6;
            SEG_7:   o_nibble = 4'h7;
            SEG_8:   o_nibble = 4'h8;
            SEG_9:   o_nibble = 4'h9;
            SEG_A:   o_nibble = 4'hA;
            SEG_B:   o_nibble = 4'hB;
            SEG_C:   o_nibble = 4'hC;
            SEG_D:   o_nibble = 4'hD;
            SEG_E:   o_nibble = 4'hE;
            SEG_F:   o_nibble = 4'hF;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// seg_capture
// Receives a time-multiplexed active-low segment bus, debounces each digit
// and rebuilds the displayed hex frame, handed off via valid/ack.
//   clock, reset   system clock, asynchronous active-high reset
//   sample_en      qualifies seg_n/dig_sel this cycle
//   seg_n          active-low segment code (bit0=a .. bit6=g)
//   dig_sel        one-hot digit select
//   frame_ack      consumer takes the frame (only while frame_valid=1)
//   hex_value      nibble i in bits [4i+3:4i]
//   digit_err      bit i set if digit i committed an illegal pattern
//   frame_valid    a complete frame is held on hex_value/digit_err
//   overrun        sticky, a commit arrived while a frame was presented
module seg_capture
    import seg_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int STABLE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sample_en,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic                  frame_ack,
    output logic [4*DIGITS-1:0]   hex_value,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid,
    output logic                  overrun
);

    localparam logic [3:0] CNT_SAT   = 4'(STABLE - 1);
    localparam logic [3:0] COMMIT_AT = 4'(STABLE - 2);

    logic [DIGITS-1:0]   r_prevSel;
    logic [6:0]          r_prevSeg;
    logic [3:0]          r_stabCnt;
    logic [4*DIGITS-1:0] r_hex;
    logic [DIGITS-1:0]   r_err;
    logic [DIGITS-1:0]   r_seen;
    logic                r_overrun;
    capState_t           r_state;
    capState_t           w_nextState;

    logic       w_oneHot;
    logic       w_sameSample;
    logic       w_commit;
    logic       w_write;
    logic       w_ackTake;
    logic [3:0] w_nibble;
    logic       w_illegal;

    assign w_oneHot     = $onehot(dig_sel);
    assign w_sameSample = (dig_sel == r_prevSel) && (seg_n == r_prevSeg);
    // The counter sits at STABLE-2 just before the STABLE-th identical
    // sample, and saturation past that point keeps the commit single-shot.
    assign w_commit     = sample_en && w_oneHot && w_sameSample &&
                          (r_stabCnt == COMMIT_AT);
    assign w_write      = w_commit && (r_state == COLLECT);
    assign w_ackTake    = frame_ack && (r_state == PRESENT);

    seg_encode u_encode (
        .i_seg     (seg_n),
        .o_nibble  (w_nibble),
        .o_illegal (w_illegal)
    );

    // Sample register and stability counter; a reset previous select of
    // zero guarantees the first sample after reset never counts as a match
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prevSel <= '0;
            r_prevSeg <= '0;
            r_stabCnt <= '0;
        end else if (sample_en) begin
            r_prevSel <= dig_sel;
            r_prevSeg <= seg_n;
            if (w_oneHot && w_sameSample) begin
                if (r_stabCnt != CNT_SAT) begin
                    r_stabCnt <= r_stabCnt + 4'd1;
                end
            end else begin
                r_stabCnt <= '0;
            end
        end
    end

    // Slot storage; writes only happen while collecting, so a presented
    // frame is frozen and the ack's clear of seen never collides with a write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hex     <= '0;
            r_err     <= '0;
            r_seen    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_ackTake) begin
                r_seen <= '0;
            end
            if (w_write) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (dig_sel[i]) begin
                        r_hex[4*i +: 4] <= w_nibble;
                        r_err[i]        <= w_illegal;
                        r_seen[i]       <= 1'b1;
                    end
                end
            end
            if (w_commit && (r_state == PRESENT)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Frame state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Frame completes one edge after the last slot lands in seen; ack is
    // only honoured while a frame is being presented
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            COLLECT: if (r_seen == '1) w_nextState = PRESENT;
            PRESENT: if (frame_ack)    w_nextState = COLLECT;
            default: w_nextState = COLLECT;
        endcase
    end

    assign hex_value   = r_hex;
    assign digit_err   = r_err;
    assign frame_valid = (r_state == PRESENT);
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture
// Directed table of scan steps, hand-written corner sequences, then random
// segment traffic compared against a frame-level reference model.
module tb_seg_capture;

    localparam int DIGITS = 6;
    localparam int STABLE = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [6:0]  seg_n;
    logic [5:0]  dig_sel;
    logic        frame_ack;
    logic [23:0] hex_value;
    logic [5:0]  digit_err;
    logic        frame_valid;
    logic        overrun;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        en;
        logic [5:0]  sel;
        logic [6:0]  seg;
        logic        ack;
        int          cycles;
        logic [23:0] expHex;
        logic [5:0]  expErr;
        logic        expValid;
        logic        expOvr;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: run length counts identical one-hot samples
    int          mRun;
    logic [5:0]  mPrevSel;
    logic [6:0]  mPrevSeg;
    logic [3:0]  mSlot[6];
    logic [5:0]  mErr;
    logic [5:0]  mSeen;
    logic        mValid;
    logic        mOvr;
    logic [6:0]  glyph[16];

    always #5 clock = ~clock;

    seg_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_en   (sample_en),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .frame_ack   (frame_ack),
        .hex_value   (hex_value),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .overrun     (overrun)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(logic en, logic [5:0] sel, logic [6:0] seg,
                                   logic ack, int cycles, logic [23:0] expHex,
                                   logic [5:0] expErr, logic expValid, logic expOvr);
        vec_t v;
        v.en = en; v.sel = sel; v.seg = seg; v.ack = ack; v.cycles = cycles;
        v.expHex = expHex; v.expErr = expErr; v.expValid = expValid; v.expOvr = expOvr;
        return v;
    endfunction

    function automatic logic [23:0] modelHex();
        logic [23:0] h;
        h = '0;
        for (int k = 0; k < 6; k++) h[4*k +: 4] = mSlot[k];
        return h;
    endfunction

    task automatic modelReset();
        mRun = 0; mPrevSel = '0; mPrevSeg = '0;
        for (int k = 0; k < 6; k++) mSlot[k] = 4'h0;
        mErr = '0; mSeen = '0; mValid = 1'b0; mOvr = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs now driven
    task automatic modelStep();
        logic       commit;
        logic       oneHot;
        logic       bad;
        logic [3:0] nib;
        logic [5:0] seenPre;
        logic       validPre;
        commit = 1'b0; seenPre = mSeen; validPre = mValid;
        if (sample_en) begin
            oneHot = ($countones(dig_sel) == 1);
            if (oneHot && dig_sel == mPrevSel && seg_n == mPrevSeg) mRun = mRun + 1;
            else mRun = oneHot ? 1 : 0;
            mPrevSel = dig_sel;
            mPrevSeg = seg_n;
            commit = oneHot && (mRun == STABLE);
        end
        bad = 1'b1; nib = 4'h0;
        for (int k = 0; k < 16; k++) begin
            if (glyph[k] == seg_n) begin
                nib = 4'(k);
                bad = 1'b0;
            end
        end
        if (validPre) begin
            if (commit) mOvr = 1'b1;
            if (frame_ack) begin
                mValid = 1'b0;
                mSeen  = '0;
            end
        end else begin
            if (commit) begin
                for (int k = 0; k < 6; k++) begin
                    if (dig_sel[k]) begin
                        mSlot[k] = nib;
                        mErr[k]  = bad;
                        mSeen[k] = 1'b1;
                    end
                end
            end
            if (seenPre == 6'h3F) mValid = 1'b1;
        end
    endtask

    task automatic checkVal(string name, logic [31:0] actual, logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(string tag, logic [23:0] expHex, logic [5:0] expErr,
                               logic expValid, logic expOvr);
        checkVal($sformatf("%s hex_value", tag), 32'(hex_value), 32'(expHex));
        checkVal($sformatf("%s digit_err", tag), 32'(digit_err), 32'(expErr));
        checkVal($sformatf("%s frame_valid", tag), 32'(frame_valid), 32'(expValid));
        checkVal($sformatf("%s overrun", tag), 32'(overrun), 32'(expOvr));
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after rising
    task automatic driveCycle(logic en, logic [5:0] sel, logic [6:0] seg, logic ack);
        @(negedge clock);
        sample_en = en; dig_sel = sel; seg_n = seg; frame_ack = ack;
        modelStep();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(logic en, logic [5:0] sel, logic [6:0] seg,
                                 logic ack, int cycles);
        for (int c = 0; c < cycles; c++) driveCycle(en, sel, seg, ack);
    endtask

    task automatic scanDigit(int idx, logic [6:0] seg, logic ack);
        applyStimulus(1'b1, 6'(1 << idx), seg, ack, STABLE);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        sample_en = 1'b0; dig_sel = '0; seg_n = '0; frame_ack = 1'b0;
        modelReset();
        #1;
        checkOutput("reset asserted", 24'h0, 6'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        reset = 1'b1; sample_en = 1'b0; dig_sel = '0; seg_n = '0; frame_ack = 1'b0;
        modelReset();

        // Latency, full scan, ack
        vecs.push_back(mkVec(1, 6'h01, 7'h30, 0, 3, 24'h000000, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h01, 7'h30, 0, 1, 24'h000003, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h01, 7'h40, 0, 4, 24'h000000, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h02, 7'h79, 0, 4, 24'h000010, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h04, 7'h24, 0, 4, 24'h000210, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h08, 7'h30, 0, 4, 24'h003210, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h10, 7'h19, 0, 4, 24'h043210, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h20, 7'h12, 0, 4, 24'h543210, 6'h00, 0, 0));
        vecs.push_back(mkVec(0, 6'h20, 7'h12, 0, 1, 24'h543210, 6'h00, 1, 0));
        vecs.push_back(mkVec(0, 6'h20, 7'h12, 1, 1, 24'h543210, 6'h00, 0, 0));
        // Blank digit 2 inside a legal frame
        vecs.push_back(mkVec(1, 6'h01, 7'h02, 0, 4, 24'h543216, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h02, 7'h78, 0, 4, 24'h543276, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h04, 7'h7F, 0, 4, 24'h543076, 6'h04, 0, 0));
        vecs.push_back(mkVec(1, 6'h08, 7'h18, 0, 4, 24'h549076, 6'h04, 0, 0));
        vecs.push_back(mkVec(1, 6'h10, 7'h08, 0, 4, 24'h5A9076, 6'h04, 0, 0));
        vecs.push_back(mkVec(1, 6'h20, 7'h03, 0, 4, 24'hBA9076, 6'h04, 0, 0));
        vecs.push_back(mkVec(0, 6'h20, 7'h03, 0, 1, 24'hBA9076, 6'h04, 1, 0));
        vecs.push_back(mkVec(0, 6'h20, 7'h03, 1, 1, 24'hBA9076, 6'h04, 0, 0));
        // Unstable pattern and a two-hot select never commit
        vecs.push_back(mkVec(1, 6'h01, 7'h00, 0, 3, 24'hBA9076, 6'h04, 0, 0));
        vecs.push_back(mkVec(1, 6'h01, 7'h18, 0, 3, 24'hBA9076, 6'h04, 0, 0));
        vecs.push_back(mkVec(1, 6'h01, 7'h00, 0, 3, 24'hBA9076, 6'h04, 0, 0));
        vecs.push_back(mkVec(1, 6'h01, 7'h18, 0, 3, 24'hBA9076, 6'h04, 0, 0));
        vecs.push_back(mkVec(1, 6'h03, 7'h40, 0, 5, 24'hBA9076, 6'h04, 0, 0));
        // Digits 1..5 only: digit 0 was never seen, so no frame yet
        vecs.push_back(mkVec(1, 6'h02, 7'h46, 0, 4, 24'hBA90C6, 6'h04, 0, 0));
        vecs.push_back(mkVec(1, 6'h04, 7'h21, 0, 4, 24'hBA9DC6, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h08, 7'h06, 0, 4, 24'hBAEDC6, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h10, 7'h0E, 0, 4, 24'hBFEDC6, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h20, 7'h40, 0, 4, 24'h0FEDC6, 6'h00, 0, 0));
        vecs.push_back(mkVec(0, 6'h20, 7'h40, 0, 2, 24'h0FEDC6, 6'h00, 0, 0));
        vecs.push_back(mkVec(1, 6'h01, 7'h79, 0, 4, 24'h0FEDC1, 6'h00, 0, 0));
        vecs.push_back(mkVec(0, 6'h01, 7'h79, 0, 1, 24'h0FEDC1, 6'h00, 1, 0));
        // Commit while presenting: frozen slots, sticky overrun
        vecs.push_back(mkVec(1, 6'h01, 7'h40, 0, 4, 24'h0FEDC1, 6'h00, 1, 1));
        vecs.push_back(mkVec(0, 6'h01, 7'h40, 1, 1, 24'h0FEDC1, 6'h00, 0, 1));
        vecs.push_back(mkVec(0, 6'h01, 7'h40, 0, 1, 24'h0FEDC1, 6'h00, 0, 1));

        #12;
        doReset();

        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].en, vecs[v].sel, vecs[v].seg, vecs[v].ack, vecs[v].cycles);
            checkOutput($sformatf("vec%0d", v), vecs[v].expHex, vecs[v].expErr,
                        vecs[v].expValid, vecs[v].expOvr);
        end

        // Ack held during the final commit is ignored while collecting
        for (int d = 0; d < 5; d++) scanDigit(d, 7'h00, 1'b0);
        checkOutput("ackcollect partial", 24'h088888, 6'h00, 1'b0, 1'b1);
        scanDigit(5, 7'h79, 1'b1);
        checkOutput("ackcollect final", 24'h188888, 6'h00, 1'b0, 1'b1);
        driveCycle(1'b0, 6'h20, 7'h79, 1'b0);
        checkOutput("ackcollect valid", 24'h188888, 6'h00, 1'b1, 1'b1);
        driveCycle(1'b0, 6'h20, 7'h79, 1'b1);
        checkOutput("ackcollect ack", 24'h188888, 6'h00, 1'b0, 1'b1);

        // Mid-frame reset drops the partial frame
        for (int d = 0; d < 4; d++) scanDigit(d, 7'h12, 1'b0);
        checkOutput("midreset before", 24'h185555, 6'h00, 1'b0, 1'b1);
        doReset();
        checkOutput("midreset after", 24'h000000, 6'h00, 1'b0, 1'b0);
        scanDigit(4, 7'h19, 1'b0);
        scanDigit(5, 7'h19, 1'b0);
        applyStimulus(1'b0, 6'h20, 7'h19, 1'b0, 2);
        checkOutput("midreset partial", 24'h440000, 6'h00, 1'b0, 1'b0);
        for (int d = 0; d < 4; d++) scanDigit(d, 7'h19, 1'b0);
        checkOutput("midreset last commit", 24'h444444, 6'h00, 1'b0, 1'b0);
        driveCycle(1'b0, 6'h08, 7'h19, 1'b0);
        checkOutput("midreset complete", 24'h444444, 6'h00, 1'b1, 1'b0);
        driveCycle(1'b0, 6'h08, 7'h19, 1'b1);
        checkOutput("midreset ack", 24'h444444, 6'h00, 1'b0, 1'b0);

        // Random traffic against the reference model
        doReset();
        for (int b = 0; b < 350; b++) begin
            logic [5:0] sel;
            logic [6:0] seg;
            int         hold;
            if ($urandom_range(0, 9) == 0) sel = 6'($urandom);
            else sel = 6'(1 << $urandom_range(0, 5));
            if ($urandom_range(0, 6) == 0) seg = 7'($urandom);
            else seg = glyph[$urandom_range(0, 15)];
            hold = $urandom_range(1, 6);
            for (int c = 0; c < hold; c++) begin
                driveCycle(($urandom_range(0, 7) != 0), sel, seg,
                           ($urandom_range(0, 3) == 0));
                checkOutput($sformatf("rand b%0d c%0d", b, c), modelHex(), mErr,
                            mValid, mOvr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
